// File: rtl/lcd_pkg.sv
// Shared encodings and default timing for the character-LCD controller FSMs.
// Timing constants are clk cycles at 50 MHz.
package lcd_pkg;

  localparam int CNT_W = 12;

  localparam int T_SETUP   = 2;
  localparam int T_ACTIVE  = 12;
  localparam int T_HOLD    = 1;
  localparam int T_GAP     = 50;
  localparam int T_RECOVER = 2000;
  localparam int POLL_MAX  = 16;

  // Same 4-bit numbering style as the write FSM.
  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_SETUP_HIGH  = 4'd1,
    ST_ACTIVE_HIGH = 4'd2,
    ST_HOLD_HIGH   = 4'd3,
    ST_GAP         = 4'd4,
    ST_SETUP_LOW   = 4'd5,
    ST_ACTIVE_LOW  = 4'd6,
    ST_HOLD_LOW    = 4'd7,
    ST_POLL_GAP    = 4'd8,
    ST_RECOVER     = 4'd9
  } lcd_rd_state_e;

  typedef enum logic [1:0] {
    STB_IDLE   = 2'd0,
    STB_SETUP  = 2'd1,
    STB_ACTIVE = 2'd2,
    STB_HOLD   = 2'd3
  } stb_phase_e;

  // True on the final cycle of a phase lasting t cycles.
  function automatic logic cnt_last(input logic [CNT_W-1:0] cnt, input int t);
    return cnt == CNT_W'(t - 1);
  endfunction

endpackage

// File: rtl/lcd_nibble_strobe.sv
// One setup / E-high / hold strobe sequence. phase_next is exposed so the parent
// can register pin levels that line up with the phase they belong to.
module lcd_nibble_strobe
  import lcd_pkg::*;
#(
  parameter int T_SETUP_P  = T_SETUP,
  parameter int T_ACTIVE_P = T_ACTIVE,
  parameter int T_HOLD_P   = T_HOLD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  output stb_phase_e phase,
  output stb_phase_e phase_next,
  output logic       sample,
  output logic       done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= STB_IDLE;
      cnt   <= '0;
    end else begin
      phase <= phase_next;
      if (phase_next != phase || phase == STB_IDLE) cnt <= '0;
      else                                          cnt <= cnt + CNT_W'(1);
    end
  end

  // go is only honoured from STB_IDLE; sample marks the last E-high cycle.
  always_comb begin
    phase_next = phase;
    sample     = 1'b0;
    done       = 1'b0;
    case (phase)
      STB_IDLE:   if (go) phase_next = STB_SETUP;
      STB_SETUP:  if (cnt_last(cnt, T_SETUP_P)) phase_next = STB_ACTIVE;
      STB_ACTIVE: begin
        if (cnt_last(cnt, T_ACTIVE_P)) begin
          phase_next = STB_HOLD;
          sample     = 1'b1;
        end
      end
      STB_HOLD: begin
        if (cnt_last(cnt, T_HOLD_P)) begin
          phase_next = STB_IDLE;
          done       = 1'b1;
        end
      end
      default: phase_next = STB_IDLE;
    endcase
  end

endmodule

// File: rtl/lcd_read_fsm.sv
// 4-bit-mode LCD read transaction with optional busy-flag polling.
// Two strobes per byte (upper nibble then lower) driven by lcd_nibble_strobe.
module lcd_read_fsm
  import lcd_pkg::*;
#(
  parameter int T_SETUP_P   = T_SETUP,
  parameter int T_ACTIVE_P  = T_ACTIVE,
  parameter int T_HOLD_P    = T_HOLD,
  parameter int T_GAP_P     = T_GAP,
  parameter int T_RECOVER_P = T_RECOVER,
  parameter int POLL_MAX_P  = POLL_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rs_sel,
  input  logic       poll_busy,
  input  logic [3:0] SF_D_in,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic       bus_own,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       timeout,
  output logic       busy,
  output logic [3:0] dbg_state,
  output logic [1:0] dbg_strobe_phase
);

  // Handshake: start is a request sampled only while idle (busy=0), never
  // queued; the result is a single-cycle valid with data_out held afterwards.

  lcd_rd_state_e    state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       poll_cnt;
  logic             rs_q, poll_q;
  logic [3:0]       upper, lower;
  logic [7:0]       byte_w;
  logic             stb_go, stb_sample, stb_done;
  stb_phase_e       stb_phase, stb_phase_next;
  logic             poll_retry, finish, rs_next, own_next;

  assign byte_w           = {upper, lower};
  assign poll_retry       = poll_q && byte_w[7] && (poll_cnt != 8'(POLL_MAX_P - 1));
  assign finish           = (state == ST_HOLD_LOW) && stb_done && !poll_retry;
  assign dbg_state        = state;
  assign dbg_strobe_phase = stb_phase;

  // Launch a strobe on the same edge the FSM enters either setup state.
  assign stb_go = ((state == ST_IDLE) && start) ||
                  (((state == ST_GAP) || (state == ST_POLL_GAP)) && cnt_last(cnt, T_GAP_P));

  lcd_nibble_strobe #(
    .T_SETUP_P  (T_SETUP_P),
    .T_ACTIVE_P (T_ACTIVE_P),
    .T_HOLD_P   (T_HOLD_P)
  ) u_strobe (
    .clk        (clk),
    .reset      (reset),
    .go         (stb_go),
    .phase      (stb_phase),
    .phase_next (stb_phase_next),
    .sample     (stb_sample),
    .done       (stb_done)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:        if (start) state_next = ST_SETUP_HIGH;
      ST_SETUP_HIGH:  if (stb_phase_next == STB_ACTIVE) state_next = ST_ACTIVE_HIGH;
      ST_ACTIVE_HIGH: if (stb_phase_next == STB_HOLD) state_next = ST_HOLD_HIGH;
      ST_HOLD_HIGH:   if (stb_done) state_next = ST_GAP;
      ST_GAP:         if (cnt_last(cnt, T_GAP_P)) state_next = ST_SETUP_LOW;
      ST_SETUP_LOW:   if (stb_phase_next == STB_ACTIVE) state_next = ST_ACTIVE_LOW;
      ST_ACTIVE_LOW:  if (stb_phase_next == STB_HOLD) state_next = ST_HOLD_LOW;
      ST_HOLD_LOW:    if (stb_done) state_next = poll_retry ? ST_POLL_GAP : ST_RECOVER;
      ST_POLL_GAP:    if (cnt_last(cnt, T_GAP_P)) state_next = ST_SETUP_HIGH;
      ST_RECOVER:     if (cnt_last(cnt, T_RECOVER_P)) state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
  end

  // Pins are registered from state_next so they change with the state itself.
  always_comb begin
    rs_next  = ((state == ST_IDLE) && start) ? (rs_sel & ~poll_busy) : rs_q;
    own_next = (state_next != ST_IDLE) && (state_next != ST_RECOVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      poll_cnt <= '0;
      rs_q     <= 1'b0;
      poll_q   <= 1'b0;
      upper    <= 4'h0;
      lower    <= 4'h0;
      LCD_RS   <= 1'b0;
      LCD_RW   <= 1'b0;
      LCD_E    <= 1'b0;
      bus_own  <= 1'b0;
      busy     <= 1'b0;
      data_out <= 8'h00;
      valid    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state || state == ST_IDLE) cnt <= '0;
      else                                         cnt <= cnt + CNT_W'(1);

      if ((state == ST_IDLE) && start) begin
        rs_q     <= rs_sel & ~poll_busy;
        poll_q   <= poll_busy;
        poll_cnt <= '0;
      end else if ((state == ST_HOLD_LOW) && stb_done && poll_retry) begin
        poll_cnt <= poll_cnt + 8'd1;
      end

      if (stb_sample && (state == ST_ACTIVE_HIGH)) upper <= SF_D_in;
      if (stb_sample && (state == ST_ACTIVE_LOW))  lower <= SF_D_in;

      LCD_E   <= (state_next == ST_ACTIVE_HIGH) || (state_next == ST_ACTIVE_LOW);
      LCD_RW  <= own_next;
      bus_own <= own_next;
      LCD_RS  <= own_next & rs_next;
      busy    <= state_next != ST_IDLE;

      valid   <= finish;
      timeout <= finish && poll_q && byte_w[7];
      if (finish) data_out <= byte_w;
    end
  end

endmodule

// File: tb/tb_lcd_read_fsm.sv
// Bench for lcd_read_fsm: an LCD responder returns queued bytes nibble by nibble,
// and expected timing/data come from the protocol's cycle arithmetic.
module tb_lcd_read_fsm;

  localparam int TS = 2, TA = 12, TH = 1, TG = 50, TR = 2000, PMAX = 16;
  localparam int RD_LEN   = 2 * (TS + TA + TH) + TG;   // one byte read, start of setup to end of hold
  localparam int RD_PER   = RD_LEN + TG;               // read-to-read period while polling
  localparam int RISE_HI  = TS + 1;
  localparam int RISE_LO  = TS + TA + TH + TG + TS + 1;

  logic       clk = 1'b0;
  logic       reset, start, rs_sel, poll_busy;
  logic [3:0] SF_D_in;
  logic       LCD_RS, LCD_RW, LCD_E, bus_own, valid, timeout, busy;
  logic [7:0] data_out;
  logic [3:0] dbg_state;
  logic [1:0] dbg_strobe_phase;

  lcd_read_fsm dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .rs_sel           (rs_sel),
    .poll_busy        (poll_busy),
    .SF_D_in          (SF_D_in),
    .LCD_RS           (LCD_RS),
    .LCD_RW           (LCD_RW),
    .LCD_E            (LCD_E),
    .bus_own          (bus_own),
    .data_out         (data_out),
    .valid            (valid),
    .timeout          (timeout),
    .busy             (busy),
    .dbg_state        (dbg_state),
    .dbg_strobe_phase (dbg_strobe_phase)
  );

  // clock / cycle count
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int t0 = 0, valid_cnt = 0, e_len = 0;
  logic exp_rs = 1'b0, mon_en = 1'b0, e_prev = 1'b0, nib_hi = 1'b1;
  logic [7:0] hb;
  logic [7:0] stim_q[$];
  logic [7:0] resp_q[$];
  logic [8:0] exp_q[$];
  int e_rise_q[$];
  int e_len_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // LCD responder and pin/scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (LCD_E && !e_prev) begin
        e_rise_q.push_back(cyc - t0);
        e_len = 0;
        if (resp_q.size() > 0) begin
          hb = resp_q[0];
          SF_D_in = nib_hi ? hb[7:4] : hb[3:0];
          if (!nib_hi) void'(resp_q.pop_front());
        end else begin
          SF_D_in = 4'h0;
        end
        nib_hi = !nib_hi;
      end
      if (LCD_E) e_len++;
      if (!LCD_E && e_prev) e_len_q.push_back(e_len);
      e_prev = LCD_E;

      if (bus_own) begin
        check("rw_read", {31'd0, LCD_RW}, 32'd1);
        check("rs_level", {31'd0, LCD_RS}, {31'd0, exp_rs});
      end else begin
        check("pins_released", {29'd0, LCD_E, LCD_RW, LCD_RS}, 32'd0);
      end

      if (valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_valid", {31'd0, valid}, 32'd0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("data_out", {24'd0, data_out}, {24'd0, e[7:0]});
          check("timeout", {31'd0, timeout}, {31'd0, e[8]});
        end
      end else begin
        check("timeout_without_valid", {31'd0, timeout}, 32'd0);
      end
    end
  end

  function automatic logic [31:0] off();
    return 32'(cyc - t0);
  endfunction

  // driver: one read request, LCD answers from stim_q; poke>0 pulses start at that offset
  task automatic run_read(input logic rs, input logic poll, input int poke, input int gap);
    int n, voff, v0;
    logic [7:0] b, last;
    n = 0;
    last = 8'h00;
    for (int i = 0; i < stim_q.size(); i++) begin
      b = stim_q[i];
      n = i + 1;
      last = b;
      if (!poll || !b[7] || n == PMAX) break;
    end
    for (int i = 0; i < n; i++) resp_q.push_back(stim_q[i]);
    stim_q.delete();
    exp_q.push_back({poll & last[7], last});
    e_rise_q.delete();
    e_len_q.delete();
    v0 = valid_cnt;
    voff = n * RD_LEN + (n - 1) * TG + 1;

    repeat (gap) @(negedge clk);
    exp_rs = rs & ~poll;
    t0 = cyc;
    start = 1'b1;
    rs_sel = rs;
    poll_busy = poll;
    @(negedge clk);
    start = 1'b0;
    rs_sel = 1'($urandom);
    poll_busy = 1'($urandom);
    while (!valid && off() < 4000) begin
      @(negedge clk);
      start = (poke > 0) && (off() == 32'(poke));
    end
    check("valid_cycle", off(), 32'(voff));
    while (busy && off() < 8000) begin
      @(negedge clk);
      start = (poke > 0) && (off() == 32'(poke));
    end
    start = 1'b0;
    check("idle_cycle", off(), 32'(voff + TR));
    check("valid_count", 32'(valid_cnt - v0), 32'd1);
    check("e_pulses", 32'(e_rise_q.size()), 32'(2 * n));
    for (int i = 0; i < e_rise_q.size() && i < 2 * n; i++)
      check("e_rise", 32'(e_rise_q[i]), 32'((i / 2) * RD_PER + ((i % 2) ? RISE_LO : RISE_HI)));
    for (int i = 0; i < e_len_q.size() && i < 2 * n; i++)
      check("e_len", 32'(e_len_q[i]), 32'(TA));
    check("reads_consumed", 32'(resp_q.size()), 32'd0);
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    resp_q.delete();
    nib_hi = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rs_sel = 1'b0;
    poll_busy = 1'b0;
    SF_D_in = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_pins", {28'd0, LCD_E, LCD_RW, LCD_RS, bus_own}, 32'd0);
    check("rst_flags", {29'd0, valid, timeout, busy}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // reset during the inter-nibble gap
    begin
      int v0;
      v0 = valid_cnt;
      resp_q.push_back(8'h41);
      exp_rs = 1'b1;
      t0 = cyc;
      start = 1'b1;
      rs_sel = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (off() < 40) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_e", {31'd0, LCD_E}, 32'd0);
      check("midrst_own", {31'd0, bus_own}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      resp_q.delete();
      nib_hi = 1'b1;
      repeat (100) @(negedge clk);
      check("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
      check("midrst_data", {24'd0, data_out}, 32'd0);
    end

    stim_q = '{8'h41};
    run_read(1'b1, 1'b0, 0, 0);
    stim_q = '{8'h25};
    run_read(1'b0, 1'b0, 0, 2);
    stim_q = '{8'h80, 8'h80, 8'h80, 8'h07};
    run_read(1'b1, 1'b1, 0, 0);
    for (int i = 0; i < PMAX; i++) stim_q.push_back(8'hFF);
    run_read(1'b0, 1'b1, 0, 1);
    stim_q = '{8'h3C};
    run_read(1'b1, 1'b0, 500, 0);

    for (int t = 0; t < 8; t++) begin
      int len;
      len = $urandom_range(0, 4);
      for (int j = 0; j < len; j++)
        stim_q.push_back({($urandom_range(0, 3) != 0), 7'($urandom)});
      stim_q.push_back({1'b0, 7'($urandom)});
      run_read(1'($urandom), 1'($urandom), 0, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
